// File: rtl/tx_link_ctrl.sv
// JESD204B TX link-layer sequencer: frame/LMFC counters, CGS/ILA/DATA stream select,
// SYNC~ resync and error-pulse detection.
module tx_link_ctrl #(
   parameter int unsigned F          = 8,
   parameter int unsigned K          = 4,
   parameter int unsigned ILA_MF     = 4,
   parameter int unsigned RESYNC_LEN = 5 * F + 9
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_link_en,
   input  logic       i_sync_n,
   output logic [2:0] o_link_mux,
   output logic [4:0] o_no_frame_de_assertion,
   output logic       o_lmfc,
   output logic       o_frame_start,
   output logic       o_user_rdy,
   output logic [2:0] o_state,
   output logic       o_resync,
   output logic       o_sync_err,
   output logic [7:0] o_err_cnt
);

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StCgs      = 3'd1,
      StWaitLmfc = 3'd2,
      StIla      = 3'd3,
      StData     = 3'd4
   } state_e;

   localparam logic [7:0] OctLast = 8'(F - 1);
   localparam logic [4:0] FrmLast = 5'(K - 1);
   localparam logic [3:0] IlaLast = 4'(ILA_MF - 1);
   localparam logic [8:0] LowLast = (RESYNC_LEN - 1 > 511) ? 9'h1ff : 9'(RESYNC_LEN - 1);

   state_e     state_q, state_d;
   logic [7:0] oct_cnt_q;
   logic [4:0] frm_cnt_q;
   logic [3:0] ila_cnt_q, ila_cnt_d;
   logic [8:0] low_cnt_q, low_cnt_d;
   logic [4:0] nfd_q, nfd_d;
   logic [7:0] err_cnt_q, err_cnt_d;
   logic [2:0] mux_q, mux_d;
   logic       rdy_q, rdy_d;
   logic       boundary, tracking, resync, sync_err;

   // LMFC phase free-runs from reset independent of the link state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         oct_cnt_q <= 8'd0;
         frm_cnt_q <= 5'd0;
      end else if (oct_cnt_q == OctLast) begin
         oct_cnt_q <= 8'd0;
         frm_cnt_q <= (frm_cnt_q == FrmLast) ? 5'd0 : frm_cnt_q + 5'd1;
      end else begin
         oct_cnt_q <= oct_cnt_q + 8'd1;
      end
   end

   assign boundary = (oct_cnt_q == OctLast) && (frm_cnt_q == FrmLast);
   assign tracking = (state_q == StIla) || (state_q == StData);

   always_comb begin
      state_d   = state_q;
      ila_cnt_d = ila_cnt_q;
      nfd_d     = nfd_q;
      err_cnt_d = err_cnt_q;
      resync    = 1'b0;
      sync_err  = 1'b0;
      if (tracking && !i_sync_n) begin
         low_cnt_d = (low_cnt_q == 9'h1ff) ? low_cnt_q : low_cnt_q + 9'd1;
      end else begin
         low_cnt_d = 9'd0;
      end

      if (!i_link_en) begin
         state_d   = StIdle;
         ila_cnt_d = 4'd0;
         low_cnt_d = 9'd0;
      end else begin
         unique case (state_q)
            StIdle: state_d = StCgs;
            StCgs: begin
               if (i_sync_n) begin
                  nfd_d   = frm_cnt_q;
                  state_d = StWaitLmfc;
               end
            end
            StWaitLmfc: begin
               if (!i_sync_n) begin
                  state_d = StCgs;
               end else if (boundary) begin
                  state_d = StIla;
               end
            end
            StIla, StData: begin
               if (!i_sync_n && low_cnt_q >= LowLast) begin
                  resync    = 1'b1;
                  state_d   = StCgs;
                  ila_cnt_d = 4'd0;
                  low_cnt_d = 9'd0;
               end else if (state_q == StIla) begin
                  if (boundary) begin
                     if (ila_cnt_q == IlaLast) begin
                        state_d   = StData;
                        ila_cnt_d = 4'd0;
                     end else begin
                        ila_cnt_d = ila_cnt_q + 4'd1;
                     end
                  end
               end else if (i_sync_n && low_cnt_q != 9'd0) begin
                  // Short low pulse ended: error report from the receiver.
                  sync_err = 1'b1;
                  if (err_cnt_q != 8'hff) begin
                     err_cnt_d = err_cnt_q + 8'd1;
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end

      unique case (state_d)
         StIla:   mux_d = 3'd2;
         StData:  mux_d = 3'd0;
         default: mux_d = 3'd1;
      endcase
      rdy_d = (state_d == StData);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         ila_cnt_q <= 4'd0;
         low_cnt_q <= 9'd0;
         nfd_q     <= 5'd0;
         err_cnt_q <= 8'd0;
         mux_q     <= 3'd1;
         rdy_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         ila_cnt_q <= ila_cnt_d;
         low_cnt_q <= low_cnt_d;
         nfd_q     <= nfd_d;
         err_cnt_q <= err_cnt_d;
         mux_q     <= mux_d;
         rdy_q     <= rdy_d;
      end
   end

   assign o_link_mux              = mux_q;
   assign o_no_frame_de_assertion = nfd_q;
   assign o_lmfc                  = boundary;
   assign o_frame_start           = (oct_cnt_q == 8'd0);
   assign o_user_rdy              = rdy_q;
   assign o_state                 = state_q;
   assign o_resync                = resync;
   assign o_sync_err              = sync_err;
   assign o_err_cnt               = err_cnt_q;

endmodule

// File: tb/tb_tx_link_ctrl.sv
// Directed/randomized bench for tx_link_ctrl, checked every cycle against a timeline
// model built from absolute cycle counts since reset.
module tb_tx_link_ctrl;
   localparam int F = 8;
   localparam int K = 4;
   localparam int ILA_MF = 4;
   localparam int RESYNC_LEN = 5 * F + 9;
   localparam int MF = F * K;
   localparam int SIdle = 0, SCgs = 1, SWait = 2, SIla = 3, SData = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       i_link_en = 1'b0;
   logic       i_sync_n = 1'b0;
   logic [2:0] o_link_mux;
   logic [4:0] o_no_frame_de_assertion;
   logic       o_lmfc, o_frame_start, o_user_rdy, o_resync, o_sync_err;
   logic [2:0] o_state;
   logic [7:0] o_err_cnt;

   tx_link_ctrl #(.F(F), .K(K), .ILA_MF(ILA_MF), .RESYNC_LEN(RESYNC_LEN)) dut (
      .clk                     (clk),
      .rst_n                   (rst_n),
      .i_link_en               (i_link_en),
      .i_sync_n                (i_sync_n),
      .o_link_mux              (o_link_mux),
      .o_no_frame_de_assertion (o_no_frame_de_assertion),
      .o_lmfc                  (o_lmfc),
      .o_frame_start           (o_frame_start),
      .o_user_rdy              (o_user_rdy),
      .o_state                 (o_state),
      .o_resync                (o_resync),
      .o_sync_err              (o_sync_err),
      .o_err_cnt               (o_err_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int ila_seen = 0;

   // Model: t = cycles since reset release; LMFC phase is pure arithmetic on t.
   int t, m_st, m_run, m_ila_start, m_nfd, m_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      t = 0; m_st = SIdle; m_run = 0; m_ila_start = 0; m_nfd = 0; m_err = 0;
   endtask

   task automatic step(input logic en, input logic sn);
      bit bnd, trk, rs, se;
      int frm, nrun;
      i_link_en = en;
      i_sync_n  = sn;
      #1;
      bnd = ((t % MF) == MF - 1);
      frm = (t / F) % K;
      trk = (m_st == SIla) || (m_st == SData);
      rs  = en && trk && !sn && (m_run + 1 >= RESYNC_LEN);
      se  = en && (m_st == SData) && sn && (m_run > 0);
      check("state", 32'(o_state), 32'(m_st));
      check("link_mux", 32'(o_link_mux), (m_st == SIla) ? 32'd2 : (m_st == SData) ? 32'd0 : 32'd1);
      check("user_rdy", 32'(o_user_rdy), 32'(m_st == SData));
      check("nfd", 32'(o_no_frame_de_assertion), 32'(m_nfd));
      check("err_cnt", 32'(o_err_cnt), 32'(m_err));
      check("lmfc", 32'(o_lmfc), 32'(bnd));
      check("frame_start", 32'(o_frame_start), 32'((t % F) == 0));
      check("resync", 32'(o_resync), 32'(rs));
      check("sync_err", 32'(o_sync_err), 32'(se));
      if (o_link_mux == 3'd2) ila_seen++;
      @(posedge clk);
      nrun = (en && trk && !rs && !sn) ? m_run + 1 : 0;
      if (!en) begin
         m_st = SIdle;
      end else begin
         case (m_st)
            SIdle: m_st = SCgs;
            SCgs: if (sn) begin m_nfd = frm; m_st = SWait; end
            SWait: begin
               if (!sn) m_st = SCgs;
               else if (bnd) begin m_st = SIla; m_ila_start = t + 1; end
            end
            SIla: begin
               if (rs) m_st = SCgs;
               else if (t + 1 - m_ila_start == ILA_MF * MF) m_st = SData;
            end
            SData: begin
               if (rs) m_st = SCgs;
               else if (se && m_err < 255) m_err++;
            end
            default: m_st = SIdle;
         endcase
      end
      m_run = nrun;
      t++;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_state", 32'(o_state), 32'd0);
      check("rst_mux", 32'(o_link_mux), 32'd1);
      check("rst_rdy", 32'(o_user_rdy), 32'd0);
      check("rst_nfd", 32'(o_no_frame_de_assertion), 32'd0);
      check("rst_err", 32'(o_err_cnt), 32'd0);
      check("rst_lmfc", 32'(o_lmfc), 32'd0);
      check("rst_resync", 32'(o_resync), 32'd0);
      check("rst_sync_err", 32'(o_sync_err), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic run(input int n, input logic en, input logic sn);
      for (int i = 0; i < n; i++) step(en, sn);
   endtask

   // Hold SYNC~ low until the counters sit at the requested frame/octet.
   task automatic wait_pos(input int frm, input int oct);
      for (int i = 0; i < 2 * MF; i++) begin
         if ((t % F) == oct && ((t / F) % K) == frm) break;
         step(1'b1, 1'b0);
      end
   endtask

   task automatic go_data();
      for (int i = 0; i < 1000; i++) begin
         if (m_st == SData) break;
         step(1'b1, 1'b1);
      end
      check("reach_data", 32'(o_state), 32'd4);
   endtask

   initial begin
      int n, len;
      model_reset();
      do_reset();
      run(5, 1'b0, 1'b0);
      run(100, 1'b1, 1'b0);

      // Release SYNC~ inside frame 2 at a random octet; ILA must last ILA_MF*K*F cycles.
      wait_pos(2, int'($urandom_range(0, F - 1)));
      step(1'b1, 1'b1);
      check("nfd_frame2", 32'(o_no_frame_de_assertion), 32'd2);
      ila_seen = 0;
      go_data();
      check("ila_len", 32'(ila_seen), 32'(ILA_MF * MF));
      run(10, 1'b1, 1'b1);

      // Short SYNC~ pulse in DATA: one error report.
      run(10, 1'b1, 1'b0);
      run(5, 1'b1, 1'b1);
      check("err_one", 32'(o_err_cnt), 32'd1);
      for (int p = 0; p < 6; p++) begin
         run(int'($urandom_range(1, RESYNC_LEN - 1)), 1'b1, 1'b0);
         run(int'($urandom_range(1, 6)), 1'b1, 1'b1);
      end

      // Long SYNC~ low: resync back to CGS.
      run(RESYNC_LEN, 1'b1, 1'b0);
      check("resync_cgs", 32'(o_state), 32'd1);
      run(20, 1'b1, 1'b0);

      // Release exactly on an LMFC boundary: ILA waits a full multiframe.
      wait_pos(K - 1, F - 1);
      step(1'b1, 1'b1);
      n = 0;
      while (o_link_mux != 3'd2 && n < 200) begin
         step(1'b1, 1'b1);
         n++;
      end
      check("ila_delay", 32'(n), 32'(MF));

      // Async reset mid-ILA.
      run(int'($urandom_range(5, 60)), 1'b1, 1'b1);
      do_reset();
      run(40, 1'b1, 1'b0);
      wait_pos(int'($urandom_range(0, K - 1)), int'($urandom_range(0, F - 1)));
      go_data();

      run(8, 1'b1, 1'b0);
      run(3, 1'b1, 1'b1);
      step(1'b0, 1'b1);
      check("en_low_idle", 32'(o_state), 32'd0);
      check("en_low_err_hold", 32'(o_err_cnt), 32'd1);
      run(10, 1'b1, 1'b0);
      go_data();

      // Many short error pulses: counter saturates.
      for (int p = 0; p < 300; p++) begin
         len = int'($urandom_range(1, 3));
         run(len, 1'b1, 1'b0);
         run(int'($urandom_range(1, 2)), 1'b1, 1'b1);
      end
      check("err_sat", 32'(o_err_cnt), 32'd255);
      check("sat_state", 32'(o_state), 32'd4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
